// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and default geometry.
// Pure functions and constants; no state, no latency.
// No handshake of its own; callers own all flow control.
package fifo_pkg;

    // Default stack geometry shared by the read and write control stages.
    localparam int STK_PTR_WIDTH = 3;
    localparam int SYNC_STAGES   = 2;

    // Widest counter the conversion helpers handle. Callers zero-extend a
    // narrower counter into gword_t and truncate the result back. Zero upper
    // bits do not disturb either conversion, so one function serves every
    // counter width.
    localparam int GRAY_MAX_W = 32;
    typedef logic [GRAY_MAX_W-1:0] gword_t;

    // Binary to reflected Gray code.
    function automatic gword_t bin2gray(input gword_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary: each bit is the XOR of all Gray bits at
    // or above it.
    function automatic gword_t gray2bin(input gword_t gray);
        gword_t bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/rd_empty_ctrl_unit_if.sv
// Read-domain control bundle between the consumer/rd_cntr_unit and rd_empty_ctrl_unit.
// Wires only; no latency of its own.
// rd_ack is the only back-pressure: no grant means the consumer's read is not taken.
interface rd_empty_ctrl_unit_if
    import fifo_pkg::*;
#(
    parameter int CW = STK_PTR_WIDTH + 1
);

    logic [CW-1:0] rd_cntr;
    logic          read_fr_stk;
    logic [CW-1:0] wr_cntr_gray;
    logic          rd_ack;
    logic [CW-1:0] rd_cntr_gray;
    logic          stk_empty;
    logic          stk_almost_empty;
    logic [CW-1:0] rd_level;
    logic          underflow_err;
    logic          ptr_err;

    // Consumer / counter side: drives requests and counters, observes status.
    modport master (
        output rd_cntr,
        output read_fr_stk,
        output wr_cntr_gray,
        input  rd_ack,
        input  rd_cntr_gray,
        input  stk_empty,
        input  stk_almost_empty,
        input  rd_level,
        input  underflow_err,
        input  ptr_err
    );

    // Control-unit side.
    modport slave (
        input  rd_cntr,
        input  read_fr_stk,
        input  wr_cntr_gray,
        output rd_ack,
        output rd_cntr_gray,
        output stk_empty,
        output stk_almost_empty,
        output rd_level,
        output underflow_err,
        output ptr_err
    );

endinterface

// File: rtl/rd_empty_ctrl_unit_sync_ff_chain.sv
// N-stage, W-bit flop chain for bringing a Gray counter into a new clock domain.
// Latency: stages clock edges from d to q.
// No back-pressure; samples d every edge.
module sync_ff_chain #(
    parameter int width  = 4,
    parameter int stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] stg [stages];

    // Shift the sampled value down the chain; synchronous clear to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < stages; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < stages; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[stages-1];

endmodule

// File: rtl/rd_empty_ctrl_unit.sv
// Read-side empty control: read grant, empty/almost-empty flags, fill level, Gray export.
// Latency: rd_ack is combinational; flags, level and Gray counter update 1 edge after the request.
// Back-pressure: rd_ack stays low while the registered empty flag is set or during reset.
module rd_empty_ctrl_unit
    import fifo_pkg::*;
#(
    parameter int stk_ptr_width       = STK_PTR_WIDTH,
    parameter int sync_stages         = SYNC_STAGES,
    parameter int almost_empty_thresh = 1
) (
    input  logic          clk_read,
    input  logic          rst,
    rd_empty_ctrl_unit_if.slave bus
);

    localparam int CW = stk_ptr_width + 1;
    typedef logic [CW-1:0] cnt_t;

    // A legal level never exceeds the stack depth.
    localparam cnt_t LVL_LIMIT = cnt_t'(1 << stk_ptr_width);
    localparam cnt_t AE_THRESH = cnt_t'(almost_empty_thresh);

    cnt_t wr_sync_gray;
    cnt_t wr_sync_bin;
    cnt_t rd_nxt;
    cnt_t lvl_nxt;
    logic rd_ack;

    cnt_t rd_cntr_gray_q;
    cnt_t rd_level_q;
    logic stk_empty_q;
    logic stk_almost_empty_q;
    logic underflow_err_q;
    logic ptr_err_q;

    // The write counter is Gray-coded at the source, so at most one bit is in
    // flight and the chain output is always a valid, possibly stale, count.
    sync_ff_chain #(
        .width  (CW),
        .stages (sync_stages)
    ) u_wr_sync (
        .clk (clk_read),
        .rst (rst),
        .d   (bus.wr_cntr_gray),
        .q   (wr_sync_gray)
    );

    // Grant, next read pointer and next level; the level uses the stale write
    // count, so empty can only be late to clear, never early.
    always_comb begin
        wr_sync_bin = cnt_t'(gray2bin(gword_t'(wr_sync_gray)));
        rd_ack      = bus.read_fr_stk & ~stk_empty_q & ~rst;
        rd_nxt      = bus.rd_cntr + cnt_t'(rd_ack);
        lvl_nxt     = wr_sync_bin - rd_nxt;
    end

    // Flag, level and exported Gray pointer registers; errors are sticky until reset.
    always_ff @(posedge clk_read) begin
        if (rst) begin
            rd_cntr_gray_q     <= '0;
            rd_level_q         <= '0;
            stk_empty_q        <= 1'b1;
            stk_almost_empty_q <= 1'b1;
            underflow_err_q    <= 1'b0;
            ptr_err_q          <= 1'b0;
        end else begin
            rd_cntr_gray_q     <= cnt_t'(bin2gray(gword_t'(rd_nxt)));
            rd_level_q         <= lvl_nxt;
            stk_empty_q        <= (lvl_nxt == '0);
            stk_almost_empty_q <= (lvl_nxt <= AE_THRESH);
            if (bus.read_fr_stk && stk_empty_q) begin
                underflow_err_q <= 1'b1;
            end
            if (lvl_nxt > LVL_LIMIT) begin
                ptr_err_q <= 1'b1;
            end
        end
    end

    assign bus.rd_ack           = rd_ack;
    assign bus.rd_cntr_gray     = rd_cntr_gray_q;
    assign bus.rd_level         = rd_level_q;
    assign bus.stk_empty        = stk_empty_q;
    assign bus.stk_almost_empty = stk_almost_empty_q;
    assign bus.underflow_err    = underflow_err_q;
    assign bus.ptr_err          = ptr_err_q;

endmodule
